// File: rtl/step_profile_gen_pkg.sv
// ---------------------------------------------------------------------------
// step_pkg
// Shared definitions for the trapezoidal step profile generator:
//   state_t      - motion state encoding used by step_profile_gen
//   params_legal - elaboration-time legality check of the profile parameters
// ---------------------------------------------------------------------------
package step_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEL,
    ST_CRUISE,
    ST_DECEL,
    ST_DONE
  } state_t;

  // The cruise velocity must leave every step period longer than two pulse
  // widths, so stretched pulses can never overlap or merge:
  //   VMIN <= VMAX < 2^ACC_W / (2*PULSE_W), ACCEL >= 1.
  // The bound is checked in integer form as 2*PULSE_W*VMAX < 2^ACC_W.
  function automatic bit params_legal(input longint acc_w,
                                      input longint vmin,
                                      input longint vmax,
                                      input longint accel,
                                      input longint pulse_w);
    longint full;
    if (acc_w < 2 || acc_w > 48 || pulse_w < 1) begin
      return 1'b0;
    end
    full = longint'(1) << acc_w;
    return (vmin <= vmax) && (vmax * 2 * pulse_w < full) && (accel >= 1);
  endfunction

endpackage

// File: rtl/step_profile_gen_stretcher.sv
// ---------------------------------------------------------------------------
// step_pulse_stretcher
// Turns a one-tick step event into a step pulse PULSE_W ticks wide. The pulse
// rises on the tick after the event and always runs to completion, whatever
// the motion controller does in the meantime.
//
// Ports:
//   int_clk    - clock
//   reset_n_i  - asynchronous active-low reset (clears pulse and counter)
//   trigger    - one-tick step event
//   pulse      - registered stretched pulse
// ---------------------------------------------------------------------------
module step_pulse_stretcher #(
  parameter int unsigned PULSE_W = 4
) (
  input  logic int_clk,
  input  logic reset_n_i,
  input  logic trigger,
  output logic pulse
);

  localparam int unsigned CNT_W = (PULSE_W < 2) ? 1 : $clog2(PULSE_W + 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of high ticks still owed after the current one.
  // Events cannot arrive while a pulse is active because the step period is
  // guaranteed to exceed twice the pulse width.
  always_ff @(posedge int_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (trigger) begin
      cnt   <= CNT_W'(PULSE_W - 1);
      pulse <= 1'b1;
    end else if (cnt != '0) begin
      cnt   <= cnt - CNT_W'(1);
      pulse <= 1'b1;
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/step_profile_gen.sv
// ---------------------------------------------------------------------------
// step_profile_gen
// Trapezoidal velocity-profile step generator. A phase accumulator advances
// by the current velocity each tick; each carry out of the accumulator is one
// step. Velocity ramps from VMIN up to VMAX, cruises, then ramps back down so
// that the move ends after exactly the commanded number of steps.
//
// Ports:
//   int_clk       - clock, one tick per rising edge
//   reset_n_i     - asynchronous active-low reset
//   cmd_valid_i   - move command valid
//   cmd_ready_o   - ready for a command (only in IDLE, and during reset)
//   cmd_steps_i   - number of steps to move
//   cmd_dir_i     - direction of the move
//   abort_i       - controlled stop request (ramp down over ramp_steps)
//   step_o        - stretched step pulse to the driver
//   dir_o         - direction to the driver, latched on command accept
//   busy_o        - high while accelerating, cruising or decelerating
//   done_o        - one-tick move-complete strobe
//   velocity_o    - current velocity in 2^-ACC_W steps per tick
// ---------------------------------------------------------------------------
module step_profile_gen
  import step_pkg::*;
#(
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned STEPS_W = 32,
  parameter int unsigned VMIN    = 1024,
  parameter int unsigned VMAX    = 65536,
  parameter int unsigned ACCEL   = 16,
  parameter int unsigned PULSE_W = 4
) (
  input  logic               int_clk,
  input  logic               reset_n_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [STEPS_W-1:0] cmd_steps_i,
  input  logic               cmd_dir_i,
  input  logic               abort_i,
  output logic               step_o,
  output logic               dir_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [ACC_W-1:0]   velocity_o
);

  if (!params_legal(longint'(ACC_W), longint'(VMIN), longint'(VMAX),
                    longint'(ACCEL), longint'(PULSE_W))) begin : g_bad_params
    $error("step_profile_gen: illegal VMIN/VMAX/ACCEL/PULSE_W for ACC_W");
  end

  localparam logic [ACC_W-1:0] VMIN_V    = ACC_W'(VMIN);
  localparam logic [ACC_W-1:0] VMAX_V    = ACC_W'(VMAX);
  localparam logic [ACC_W-1:0] ACCEL_V   = ACC_W'(ACCEL);
  localparam logic [ACC_W:0]   ACCEL_W1  = (ACC_W + 1)'(ACCEL);

  state_t             state;
  logic [ACC_W-1:0]   phase;
  logic [ACC_W-1:0]   v;
  logic [STEPS_W-1:0] remaining;
  logic [STEPS_W-1:0] ramp_steps;

  logic               moving;
  logic [ACC_W:0]     phase_sum;
  logic [ACC_W-1:0]   phase_next;
  logic               step_evt;
  logic [STEPS_W-1:0] rem_post;
  logic [STEPS_W-1:0] ramp_eff;
  logic [STEPS_W-1:0] rem_abort;
  logic [ACC_W:0]     v_up_wide;
  logic [ACC_W-1:0]   v_up;
  logic [ACC_W-1:0]   v_down;

  // Post-update datapath values for the current tick. The transition checks
  // in the state machine compare these, not the pre-update registers.
  // A carry with nothing left to step is dropped so remaining can never wrap.
  always_comb begin
    moving     = (state == ST_ACCEL) || (state == ST_CRUISE) || (state == ST_DECEL);
    phase_sum  = {1'b0, phase} + {1'b0, v};
    phase_next = phase_sum[ACC_W-1:0];
    step_evt   = moving && phase_sum[ACC_W] && (remaining != '0);
    rem_post   = step_evt ? (remaining - STEPS_W'(1)) : remaining;

    // Only steps taken while accelerating count towards the braking distance.
    ramp_eff = ramp_steps;
    if ((state == ST_ACCEL) && step_evt && (ramp_steps != '1)) begin
      ramp_eff = ramp_steps + STEPS_W'(1);
    end

    rem_abort = (rem_post < ramp_eff) ? rem_post : ramp_eff;

    v_up_wide = {1'b0, v} + ACCEL_W1;
    v_up      = (v_up_wide >= {1'b0, VMAX_V}) ? VMAX_V : v_up_wide[ACC_W-1:0];

    if ({1'b0, v} <= ({1'b0, VMIN_V} + ACCEL_W1)) begin
      v_down = VMIN_V;
    end else begin
      v_down = v - ACCEL_V;
    end
  end

  // Motion state machine with all status outputs registered alongside it.
  // cmd_ready_o resets high so a command can be presented straight after reset.
  always_ff @(posedge int_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= ST_IDLE;
      phase       <= '0;
      v           <= '0;
      remaining   <= '0;
      ramp_steps  <= '0;
      dir_o       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cmd_ready_o <= 1'b1;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            dir_o       <= cmd_dir_i;
            remaining   <= cmd_steps_i;
            v           <= VMIN_V;
            phase       <= '0;
            ramp_steps  <= '0;
            cmd_ready_o <= 1'b0;
            if (cmd_steps_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state  <= ST_ACCEL;
              busy_o <= 1'b1;
            end
          end
        end

        // Braking check wins over reaching cruise speed, and an abort clamps
        // the remaining distance to what the ramp-down needs.
        ST_ACCEL, ST_CRUISE: begin
          phase      <= phase_next;
          remaining  <= rem_post;
          ramp_steps <= ramp_eff;
          if (state == ST_ACCEL) begin
            v <= v_up;
          end
          if (abort_i) begin
            remaining <= rem_abort;
            state     <= ST_DECEL;
          end else if (rem_post <= ramp_eff) begin
            state <= ST_DECEL;
          end else if ((state == ST_ACCEL) && (v_up == VMAX_V)) begin
            state <= ST_CRUISE;
          end
        end

        ST_DECEL: begin
          phase     <= phase_next;
          remaining <= rem_post;
          v         <= v_down;
          if (rem_post == '0) begin
            state  <= ST_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end

        ST_DONE: begin
          v           <= '0;
          state       <= ST_IDLE;
          cmd_ready_o <= 1'b1;
        end

        default: begin
          state       <= ST_IDLE;
          v           <= '0;
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
        end
      endcase
    end
  end

  assign velocity_o = v;

  step_pulse_stretcher #(
    .PULSE_W(PULSE_W)
  ) u_stretcher (
    .int_clk  (int_clk),
    .reset_n_i(reset_n_i),
    .trigger  (step_evt),
    .pulse    (step_o)
  );

endmodule

// File: tb/tb_step_profile_gen.sv
// ---------------------------------------------------------------------------
// tb_step_profile_gen
// Self-checking bench for step_profile_gen. A tick-level reference model of
// the motion profile predicts every output each tick; table-driven moves and
// hand-written sequences check pulse counts, ramp timing, zero-length moves,
// abort behaviour and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_step_profile_gen;

  localparam int ACC_W   = 16;
  localparam int STEPS_W = 32;
  localparam int VMIN    = 1024;
  localparam int VMAX    = 8192;
  localparam int ACCEL   = 16'd64;
  localparam int PULSE_W = 2;
  localparam int FULL    = 1 << ACC_W;

  localparam int M_IDLE   = 0;
  localparam int M_UP     = 1;
  localparam int M_CRUISE = 2;
  localparam int M_DOWN   = 3;
  localparam int M_DONE   = 4;

  logic               int_clk = 1'b0;
  logic               reset_n_i = 1'b0;
  logic               cmd_valid_i = 1'b0;
  logic               cmd_ready_o;
  logic [STEPS_W-1:0] cmd_steps_i = '0;
  logic               cmd_dir_i = 1'b0;
  logic               abort_i = 1'b0;
  logic               step_o;
  logic               dir_o;
  logic               busy_o;
  logic               done_o;
  logic [ACC_W-1:0]   velocity_o;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int m_mode, m_phase, m_v, m_rem, m_ramp, m_dir;
  int m_tick, m_last_carry, m_carries;

  // observation state
  int dut_pulses;
  bit prev_step;
  int r_pulses, r_model_pulses, r_dones, r_peak, r_first_vmax, r_ramp_at_abort;
  int r_vel_at_abort, r_vel_at_done;
  bit r_timeout;

  typedef struct {
    int steps;
    bit dir;
    int exp_pulses;
    int exp_first_vmax;
  } vec_t;

  vec_t tbl[5];

  step_profile_gen #(
    .ACC_W  (ACC_W),
    .STEPS_W(STEPS_W),
    .VMIN   (VMIN),
    .VMAX   (VMAX),
    .ACCEL  (ACCEL),
    .PULSE_W(PULSE_W)
  ) dut (
    .int_clk    (int_clk),
    .reset_n_i  (reset_n_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_steps_i(cmd_steps_i),
    .cmd_dir_i  (cmd_dir_i),
    .abort_i    (abort_i),
    .step_o     (step_o),
    .dir_o      (dir_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .velocity_o (velocity_o)
  );

  always #5 int_clk = ~int_clk;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_mode       = M_IDLE;
    m_phase      = 0;
    m_v          = 0;
    m_rem        = 0;
    m_ramp       = 0;
    m_dir        = 0;
    m_tick       = 0;
    m_last_carry = -100;
  endtask

  // One tick of the profile, computed from the motion rules with plain
  // integer arithmetic on the inputs present at that clock edge.
  task automatic model_tick(input bit valid, input int steps, input bit dir, input bit abort);
    int sum;
    bit carry;
    m_tick++;
    case (m_mode)
      M_IDLE: begin
        if (valid) begin
          m_dir   = dir;
          m_rem   = steps;
          m_v     = VMIN;
          m_phase = 0;
          m_ramp  = 0;
          m_mode  = (steps == 0) ? M_DONE : M_UP;
        end
      end
      M_UP, M_CRUISE, M_DOWN: begin
        sum     = m_phase + m_v;
        carry   = (sum >= FULL) && (m_rem > 0);
        m_phase = sum % FULL;
        if (carry) begin
          m_rem--;
          m_last_carry = m_tick;
          m_carries++;
          if (m_mode == M_UP) m_ramp++;
        end
        if (m_mode == M_DOWN) begin
          m_v = (m_v - ACCEL < VMIN) ? VMIN : m_v - ACCEL;
          if (m_rem == 0) m_mode = M_DONE;
        end else begin
          if (m_mode == M_UP) m_v = (m_v + ACCEL > VMAX) ? VMAX : m_v + ACCEL;
          if (abort) begin
            if (m_ramp < m_rem) m_rem = m_ramp;
            m_mode = M_DOWN;
          end else if (m_rem <= m_ramp) begin
            m_mode = M_DOWN;
          end else if (m_mode == M_UP && m_v == VMAX) begin
            m_mode = M_CRUISE;
          end
        end
      end
      M_DONE: begin
        m_v    = 0;
        m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // Drive inputs for one tick, advance the model on the edge, then compare
  // the DUT with the model half a cycle later.
  task automatic apply_stimulus(input bit valid, input int steps, input bit dir, input bit abort);
    logic [20:0] exp_vec;
    logic [20:0] act_vec;
    bit exp_step;
    cmd_valid_i = valid;
    cmd_steps_i = STEPS_W'(steps);
    cmd_dir_i   = dir;
    abort_i     = abort;
    @(posedge int_clk);
    model_tick(valid, steps, dir, abort);
    @(negedge int_clk);
    exp_step = ((m_tick - m_last_carry) < PULSE_W);
    exp_vec  = {m_v[15:0], exp_step, m_dir[0],
                (m_mode == M_UP || m_mode == M_CRUISE || m_mode == M_DOWN),
                (m_mode == M_DONE), (m_mode == M_IDLE)};
    act_vec  = {velocity_o, step_o, dir_o, busy_o, done_o, cmd_ready_o};
    check_output($sformatf("tick%0d {vel,step,dir,busy,done,ready}", m_tick), act_vec, exp_vec);
    if (step_o && !prev_step) dut_pulses++;
    prev_step = step_o;
  endtask

  task automatic observe(input int k);
    if (int'(velocity_o) > r_peak) r_peak = int'(velocity_o);
    if (int'(velocity_o) == VMAX && r_first_vmax < 0) r_first_vmax = k;
    if (done_o) begin
      r_dones++;
      r_vel_at_done = int'(velocity_o);
    end
  endtask

  // Accept one move and run it to completion (bounded), optionally aborting
  // after a pulse count or tick count, and optionally driving random noise
  // on the command and abort inputs while the move is in flight.
  task automatic run_move(input int steps, input bit dir, input int abort_pulses,
                          input int abort_tick, input bit noise, input bit hold_valid);
    int k;
    int start_carries;
    bit aborted;
    bit v_drive;
    bit a_drive;
    r_peak = 0; r_first_vmax = -1; r_dones = 0; r_timeout = 0;
    r_ramp_at_abort = -1; r_vel_at_abort = -1; r_vel_at_done = -1;
    dut_pulses    = 0;
    start_carries = m_carries;
    aborted       = 1'b0;
    apply_stimulus(1'b1, steps, dir, 1'b0);
    k = 0;
    observe(k);
    while (m_mode != M_IDLE) begin
      if (k > 20000) begin
        r_timeout = 1'b1;
        break;
      end
      a_drive = 1'b0;
      if (!aborted && ((abort_pulses >= 0 && dut_pulses >= abort_pulses) ||
                       (abort_tick >= 0 && k >= abort_tick))) begin
        a_drive        = 1'b1;
        aborted        = 1'b1;
        r_vel_at_abort = int'(velocity_o);
      end
      if (noise && m_mode == M_DOWN && $urandom_range(0, 3) == 0) a_drive = 1'b1;
      v_drive = hold_valid;
      if (noise) v_drive = ($urandom_range(0, 3) == 0);
      apply_stimulus(v_drive, noise ? int'($urandom_range(0, 50)) : steps,
                     noise ? bit'($urandom_range(0, 1)) : !dir, a_drive);
      if (a_drive && r_ramp_at_abort < 0) r_ramp_at_abort = m_ramp;
      k++;
      observe(k);
    end
    repeat (PULSE_W + 2) apply_stimulus(1'b0, 0, 1'b0, 1'b0);
    r_pulses       = dut_pulses;
    r_model_pulses = m_carries - start_carries;
  endtask

  initial begin
    int n;
    int exp_total;

    tbl[0] = '{1000, 1'b1, 1000, 112};
    tbl[1] = '{10,   1'b0, 10,   -1};
    tbl[2] = '{1,    1'b1, 1,    -1};
    tbl[3] = '{3,    1'b0, 3,    -1};
    tbl[4] = '{40,   1'b1, 40,   112};

    m_carries = 0;
    model_reset();
    prev_step  = 1'b0;
    dut_pulses = 0;

    // reset and release
    reset_n_i = 1'b0;
    repeat (3) @(negedge int_clk);
    check_output("ready_during_reset", cmd_ready_o, 1);
    reset_n_i = 1'b1;
    #1;
    check_output("reset_state {step,busy,done,vel,ready}",
                 {step_o, busy_o, done_o, velocity_o, cmd_ready_o},
                 {1'b0, 1'b0, 1'b0, 16'd0, 1'b1});

    // table-driven moves
    for (int i = 0; i < 5; i++) begin
      run_move(tbl[i].steps, tbl[i].dir, -1, -1, 1'b0, 1'b0);
      check_output($sformatf("timeout[%0d]", i), r_timeout, 0);
      check_output($sformatf("pulses[%0d]", i), r_pulses, tbl[i].exp_pulses);
      check_output($sformatf("model_pulses[%0d]", i), r_pulses, r_model_pulses);
      check_output($sformatf("done_count[%0d]", i), r_dones, 1);
      check_output($sformatf("first_vmax_tick[%0d]", i), r_first_vmax, tbl[i].exp_first_vmax);
      if (tbl[i].exp_first_vmax < 0)
        check_output($sformatf("peak_below_vmax[%0d]", i), r_peak < VMAX, 1);
      check_output($sformatf("dir_hold[%0d]", i), dir_o, tbl[i].dir);
      check_output($sformatf("ready_after[%0d]", i), cmd_ready_o, 1);
    end

    // zero-length move: done the tick after accept, back to IDLE the next
    dut_pulses = 0;
    apply_stimulus(1'b1, 0, 1'b1, 1'b0);
    check_output("zero_done {done,busy,ready}", {done_o, busy_o, cmd_ready_o}, 3'b100);
    apply_stimulus(1'b0, 0, 1'b0, 1'b0);
    check_output("zero_idle {done,ready,vel}", {done_o, cmd_ready_o, velocity_o}, {2'b01, 16'd0});
    repeat (4) apply_stimulus(1'b0, 0, 1'b0, 1'b0);
    check_output("zero_pulses", dut_pulses, 0);
    check_output("zero_dir", dir_o, 1);

    // abort in cruise after pulse 500 with cmd_valid held high throughout
    run_move(1000, 1'b0, 500, -1, 1'b0, 1'b1);
    exp_total = 500 + ((r_ramp_at_abort < 500) ? r_ramp_at_abort : 500);
    check_output("abort_timeout", r_timeout, 0);
    check_output("abort_in_cruise_vel", r_vel_at_abort, VMAX);
    check_output("abort_pulses", r_pulses, exp_total);
    check_output("abort_model_pulses", r_pulses, r_model_pulses);
    check_output("abort_done_count", r_dones, 1);
    check_output("abort_done_vel_range", (r_vel_at_done >= VMIN) && (r_vel_at_done < VMAX), 1);
    check_output("abort_ready_after", {cmd_ready_o, busy_o}, 2'b10);

    // randomized moves with random aborts and input noise
    for (int i = 0; i < 20; i++) begin
      int steps;
      int atick;
      bit rdir;
      steps = $urandom_range(0, 80);
      rdir  = bit'($urandom_range(0, 1));
      atick = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 400)) : -1;
      run_move(steps, rdir, -1, atick, 1'b1, 1'b0);
      check_output($sformatf("rnd_timeout[%0d]", i), r_timeout, 0);
      check_output($sformatf("rnd_model_pulses[%0d]", i), r_pulses, r_model_pulses);
      if (atick < 0 || r_ramp_at_abort < 0)
        check_output($sformatf("rnd_pulses[%0d]", i), r_pulses, steps);
      check_output($sformatf("rnd_done_count[%0d]", i), r_dones, 1);
      repeat ($urandom_range(0, 3)) apply_stimulus(1'b0, 0, 1'b0, 1'b0);
    end

    // asynchronous reset in cruise while a pulse is high
    apply_stimulus(1'b1, 1000, 1'b1, 1'b0);
    n = 0;
    while (!(step_o && int'(velocity_o) == VMAX) && n < 3000) begin
      apply_stimulus(1'b0, 0, 1'b0, 1'b0);
      n++;
    end
    check_output("reach_cruise_pulse", n < 3000, 1);
    reset_n_i = 1'b0;
    #1;
    check_output("async_reset {step,busy,done,dir,ready,vel}",
                 {step_o, busy_o, done_o, dir_o, cmd_ready_o, velocity_o},
                 {5'b00001, 16'd0});
    model_reset();
    prev_step  = 1'b0;
    dut_pulses = 0;
    repeat (3) @(negedge int_clk);
    check_output("ready_in_reset2", cmd_ready_o, 1);
    reset_n_i = 1'b1;
    repeat (200) apply_stimulus(1'b0, 0, 1'b0, 1'b0);
    check_output("post_reset_pulses", dut_pulses, 0);
    check_output("post_reset_idle {busy,ready}", {busy_o, cmd_ready_o}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
